// File: rtl/boot_loader_fsm.sv
// Boot loader: parses UART byte frames and writes I-mem, D-mem or the image buffer.
// Define BOOT_CHECKSUM_EN to require a trailing 8-bit sum byte on every non-empty frame.
module boot_loader_fsm #(
  parameter int BITS  = 32,
  parameter int IB_DW = 3072,
  parameter int IB_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             imem_we,
  output logic [10:0]      imem_addr,
  output logic [BITS-1:0]  imem_wdata,
  output logic             dmem_we,
  output logic [12:0]      dmem_addr,
  output logic [BITS-1:0]  dmem_wdata,
  output logic             ib_we,
  output logic [IB_AW-1:0] ib_addr,
  output logic [IB_DW-1:0] ib_wdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int          BUF_W    = (IB_DW > BITS) ? IB_DW : BITS;
  localparam int          IDXW     = $clog2(BUF_W);
  localparam logic [15:0] MEM_LAST = 16'(BITS / 8 - 1);
  localparam logic [15:0] IB_LAST  = 16'(IB_DW / 8 - 1);

  localparam logic [7:0] HDR_IMEM = 8'h04;
  localparam logic [7:0] HDR_DMEM = 8'h02;
  localparam logic [7:0] HDR_IB   = 8'h01;
  localparam logic [7:0] HDR_END  = 8'h00;

  typedef enum logic [3:0] {
    HDR,
    ADDR0,
    ADDR1,
    CNT0,
    CNT1,
    DATA,
`ifdef BOOT_CHECKSUM_EN
    CKSUM,
`endif
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    DST_IMEM = 2'd0,
    DST_DMEM = 2'd1,
    DST_IB   = 2'd2
  } dest_t;

  state_t           state;
  state_t           next_state;
  dest_t            dest;
  logic [15:0]      waddr;
  logic [15:0]      cnt;
  logic [15:0]      word_cnt;
  logic [15:0]      byte_cnt;
  logic [BUF_W-1:0] line_buf;
  logic [BUF_W-1:0] merged;
  logic [IDXW-1:0]  byte_pos;
  logic             word_last;
  logic             frame_last;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       cksum;
`endif

  function automatic logic [BUF_W-1:0] insert_byte(
    input logic [BUF_W-1:0] line,
    input logic [IDXW-1:0]  pos,
    input logic [7:0]       data
  );
    logic [BUF_W-1:0] res;
    res = line;
    res[pos +: 8] = data;
    return res;
  endfunction

  // Byte placement within the current word and end-of-word / end-of-frame detection.
  always_comb begin
    byte_pos = {byte_cnt[IDXW-4:0], 3'b000};
    merged   = insert_byte(line_buf, byte_pos, rx_data);
    if (dest == DST_IB) begin
      word_last = (byte_cnt == IB_LAST);
    end else begin
      word_last = (byte_cnt == MEM_LAST);
    end
    frame_last = ((word_cnt + 16'd1) == cnt);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HDR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; DONE and ERR hold until reset.
  always_comb begin
    next_state = state;
    case (state)
      HDR: begin
        if (rx_valid) begin
          if (rx_data == HDR_END) begin
            next_state = DONE;
          end else if ((rx_data == HDR_IMEM) || (rx_data == HDR_DMEM) || (rx_data == HDR_IB)) begin
            next_state = ADDR0;
          end else begin
            next_state = ERR;
          end
        end else begin
          next_state = HDR;
        end
      end
      ADDR0: begin
        if (rx_valid) next_state = ADDR1;
        else          next_state = ADDR0;
      end
      ADDR1: begin
        if (rx_valid) next_state = CNT0;
        else          next_state = ADDR1;
      end
      CNT0: begin
        if (rx_valid) next_state = CNT1;
        else          next_state = CNT0;
      end
      CNT1: begin
        if (rx_valid) begin
          if ({rx_data, cnt[7:0]} == 16'd0) next_state = HDR;
          else                              next_state = DATA;
        end else begin
          next_state = CNT1;
        end
      end
      DATA: begin
        if (rx_valid && word_last && frame_last) begin
`ifdef BOOT_CHECKSUM_EN
          next_state = CKSUM;
`else
          next_state = HDR;
`endif
        end else begin
          next_state = DATA;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CKSUM: begin
        if (rx_valid) begin
          if (rx_data == cksum) next_state = HDR;
          else                  next_state = ERR;
        end else begin
          next_state = CKSUM;
        end
      end
`endif
      DONE:    next_state = DONE;
      ERR:     next_state = ERR;
      default: next_state = ERR;
    endcase
  end

  // Frame fields, word assembly, write strobes and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest       <= DST_IMEM;
      waddr      <= 16'd0;
      cnt        <= 16'd0;
      word_cnt   <= 16'd0;
      byte_cnt   <= 16'd0;
      line_buf   <= '0;
`ifdef BOOT_CHECKSUM_EN
      cksum      <= 8'd0;
`endif
      imem_we    <= 1'b0;
      imem_addr  <= 11'd0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 13'd0;
      dmem_wdata <= '0;
      ib_we      <= 1'b0;
      ib_addr    <= '0;
      ib_wdata   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      ib_we   <= 1'b0;
      busy    <= (next_state != HDR) && (next_state != DONE) && (next_state != ERR);
      done    <= (next_state == DONE);
      err     <= (next_state == ERR);
      if (rx_valid) begin
        case (state)
          HDR: begin
            byte_cnt <= 16'd0;
            word_cnt <= 16'd0;
`ifdef BOOT_CHECKSUM_EN
            cksum    <= 8'd0;
`endif
            case (rx_data)
              HDR_IMEM: dest <= DST_IMEM;
              HDR_DMEM: dest <= DST_DMEM;
              default:  dest <= DST_IB;
            endcase
          end
          ADDR0: waddr[7:0]  <= rx_data;
          ADDR1: waddr[15:8] <= rx_data;
          CNT0:  cnt[7:0]    <= rx_data;
          CNT1:  cnt[15:8]   <= rx_data;
          DATA: begin
            line_buf <= merged;
`ifdef BOOT_CHECKSUM_EN
            cksum    <= cksum + rx_data;
`endif
            if (word_last) begin
              byte_cnt <= 16'd0;
              word_cnt <= word_cnt + 16'd1;
              waddr    <= waddr + 16'd1;
              case (dest)
                DST_IMEM: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= waddr[10:0];
                  imem_wdata <= merged[BITS-1:0];
                end
                DST_DMEM: begin
                  dmem_we    <= 1'b1;
                  dmem_addr  <= waddr[12:0];
                  dmem_wdata <= merged[BITS-1:0];
                end
                DST_IB: begin
                  ib_we    <= 1'b1;
                  ib_addr  <= waddr[IB_AW-1:0];
                  ib_wdata <= merged[IB_DW-1:0];
                end
                default: begin
                  imem_we <= 1'b0;
                end
              endcase
            end else begin
              byte_cnt <= byte_cnt + 16'd1;
            end
          end
          default: begin
            byte_cnt <= byte_cnt;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader_fsm.sv
// Directed self-checking bench for boot_loader_fsm; works with or without BOOT_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_boot_loader_fsm;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          imem_we;
  logic [10:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          dmem_we;
  logic [12:0]   dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          ib_we;
  logic [7:0]    ib_addr;
  logic [3071:0] ib_wdata;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;

  int          im_cnt = 0;
  int          dm_cnt = 0;
  int          ib_cnt = 0;
  int          multi_we = 0;
  logic [10:0] im_addr_log [0:63];
  logic [31:0] im_data_log [0:63];
  logic [12:0] dm_addr_log [0:63];
  logic [31:0] dm_data_log [0:63];
  logic [7:0]    ib_addr_last = 8'h00;
  logic [3071:0] ib_data_last = '0;

  boot_loader_fsm #(.BITS(32), .IB_DW(3072), .IB_AW(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .ib_we(ib_we), .ib_addr(ib_addr), .ib_wdata(ib_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if ((int'(imem_we) + int'(dmem_we) + int'(ib_we)) > 1) multi_we = multi_we + 1;
    if (imem_we === 1'b1) begin
      im_addr_log[im_cnt % 64] = imem_addr;
      im_data_log[im_cnt % 64] = imem_wdata;
      im_cnt = im_cnt + 1;
    end
    if (dmem_we === 1'b1) begin
      dm_addr_log[dm_cnt % 64] = dmem_addr;
      dm_data_log[dm_cnt % 64] = dmem_wdata;
      dm_cnt = dm_cnt + 1;
    end
    if (ib_we === 1'b1) begin
      ib_addr_last = ib_addr;
      ib_data_last = ib_wdata;
      ib_cnt = ib_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
  endtask

  task automatic send_cksum(input logic [7:0] b);
`ifdef BOOT_CHECKSUM_EN
    send_byte(b);
`endif
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err});
    end
    checks++;
    if ({imem_we, dmem_we, ib_we} !== 3'b000) begin
      failures++; $display("FAIL reset_we got=%b exp=000", {imem_we, dmem_we, ib_we});
    end
    checks++;
    if ({imem_addr, dmem_addr, ib_addr, imem_wdata, dmem_wdata} !== '0 || ib_wdata !== '0) begin
      failures++; $display("FAIL reset_addr_data got=%h/%h/%h/%h/%h exp=0",
                           imem_addr, dmem_addr, ib_addr, imem_wdata, dmem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_imem();
    int base;
    do_reset();
    base = im_cnt;
    send_byte(8'h04);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL imem_busy got=%b exp=1", busy);
    end
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_cksum(8'hB6);
    settle();
    checks++;
    if (im_cnt - base !== 2) begin
      failures++; $display("FAIL imem_count got=%0d exp=2", im_cnt - base);
    end
    checks++;
    if (im_addr_log[base % 64] !== 11'h010 || im_data_log[base % 64] !== 32'h0000_0013) begin
      failures++; $display("FAIL imem_word0 got=%h/%h exp=010/00000013",
                           im_addr_log[base % 64], im_data_log[base % 64]);
    end
    checks++;
    if (im_addr_log[(base + 1) % 64] !== 11'h011 || im_data_log[(base + 1) % 64] !== 32'h0010_0093) begin
      failures++; $display("FAIL imem_word1 got=%h/%h exp=011/00100093",
                           im_addr_log[(base + 1) % 64], im_data_log[(base + 1) % 64]);
    end
    checks++;
    if ({busy, err} !== 2'b00) begin
      failures++; $display("FAIL imem_end_flags got=%b exp=00", {busy, err});
    end
  endtask

  task automatic test_dmem_wrap();
    int base;
    do_reset();
    base = dm_cnt;
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h1F); send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
    send_cksum(8'hA4);
    settle();
    checks++;
    if (dm_cnt - base !== 2) begin
      failures++; $display("FAIL dmem_count got=%0d exp=2", dm_cnt - base);
    end
    checks++;
    if (dm_addr_log[base % 64] !== 13'h1FFF || dm_data_log[base % 64] !== 32'h1413_1211) begin
      failures++; $display("FAIL dmem_word0 got=%h/%h exp=1fff/14131211",
                           dm_addr_log[base % 64], dm_data_log[base % 64]);
    end
    checks++;
    if (dm_addr_log[(base + 1) % 64] !== 13'h0000 || dm_data_log[(base + 1) % 64] !== 32'h1817_1615) begin
      failures++; $display("FAIL dmem_wrap got=%h/%h exp=0000/18171615",
                           dm_addr_log[(base + 1) % 64], dm_data_log[(base + 1) % 64]);
    end
  endtask

  // Whole frame with rx_valid held high: one byte per cycle.
  task automatic test_back_to_back_ib();
    int ib_base;
    int im_base;
    int dm_base;
    logic [7:0] hdr [0:4];
    logic [7:0] b;
    do_reset();
    ib_base = ib_cnt; im_base = im_cnt; dm_base = dm_cnt;
    hdr[0] = 8'h01; hdr[1] = 8'h05; hdr[2] = 8'h00; hdr[3] = 8'h01; hdr[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = hdr[i];
    end
    for (int i = 0; i < 384; i++) begin
      b = 8'(i);
      @(negedge clk); rx_valid = 1'b1; rx_data = b;
    end
`ifdef BOOT_CHECKSUM_EN
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h40;
`endif
    @(negedge clk); rx_valid = 1'b0;
    settle();
    checks++;
    if (ib_cnt - ib_base !== 1 || im_cnt !== im_base || dm_cnt !== dm_base) begin
      failures++; $display("FAIL ib_count got=%0d/%0d/%0d exp=1/0/0",
                           ib_cnt - ib_base, im_cnt - im_base, dm_cnt - dm_base);
    end
    checks++;
    if (ib_addr_last !== 8'h05) begin
      failures++; $display("FAIL ib_addr got=%h exp=05", ib_addr_last);
    end
    checks++;
    if (ib_data_last[7:0] !== 8'h00 || ib_data_last[15:8] !== 8'h01 ||
        ib_data_last[3071:3064] !== 8'h7F || ib_data_last[2047:2040] !== 8'hFF) begin
      failures++; $display("FAIL ib_data got=%h/%h/%h/%h exp=00/01/7f/ff", ib_data_last[7:0],
                           ib_data_last[15:8], ib_data_last[3071:3064], ib_data_last[2047:2040]);
    end
    checks++;
    if ({busy, err} !== 2'b00) begin
      failures++; $display("FAIL ib_end_flags got=%b exp=00", {busy, err});
    end
  endtask

  task automatic test_cnt_zero();
    int im_base;
    int dm_base;
    do_reset();
    im_base = im_cnt; dm_base = dm_cnt;
    send_byte(8'h04); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    settle();
    checks++;
    if (busy !== 1'b0 || im_cnt !== im_base) begin
      failures++; $display("FAIL cnt_zero got=busy%b/writes%0d exp=0/0", busy, im_cnt - im_base);
    end
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_cksum(8'h0E);
    settle();
    checks++;
    if (dm_cnt - dm_base !== 1 || dm_addr_log[dm_base % 64] !== 13'h0000 ||
        dm_data_log[dm_base % 64] !== 32'hDDCC_BBAA) begin
      failures++; $display("FAIL cnt_zero_next got=%0d/%h/%h exp=1/0000/ddccbbaa",
                           dm_cnt - dm_base, dm_addr_log[dm_base % 64], dm_data_log[dm_base % 64]);
    end
  endtask

  task automatic test_bad_header();
    do_reset();
    send_byte(8'h07);
    settle();
    checks++;
    if ({err, busy, done} !== 3'b100) begin
      failures++; $display("FAIL bad_hdr got=%b exp=100", {err, busy, done});
    end
    send_byte(8'h04);
    settle();
    checks++;
    if ({err, busy} !== 2'b10) begin
      failures++; $display("FAIL err_terminal got=%b exp=10", {err, busy});
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_cleared got=%b exp=0", err);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    base = im_cnt;
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    checks++;
    if (im_cnt - base !== 1) begin
      failures++; $display("FAIL midframe_pre got=%0d exp=1", im_cnt - base);
    end
    do_reset();
    base = im_cnt;
    send_byte(8'h00);
    settle();
    checks++;
    if (im_cnt !== base || {done, busy, err} !== 3'b100) begin
      failures++; $display("FAIL midframe_post got=writes%0d/%b exp=0/100", im_cnt - base, {done, busy, err});
    end
    send_byte(8'h04);
    settle();
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++; $display("FAIL done_terminal got=%b exp=10", {done, busy});
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    int base;
    do_reset();
    base = dm_cnt;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0A);
    settle();
    checks++;
    if ({err, busy} !== 2'b00 || dm_cnt - base !== 1 || dm_data_log[base % 64] !== 32'h0403_0201) begin
      failures++; $display("FAIL cksum_good got=%b/%0d/%h exp=00/1/04030201",
                           {err, busy}, dm_cnt - base, dm_data_log[base % 64]);
    end
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0B);
    settle();
    checks++;
    if (err !== 1'b1 || dm_cnt - base !== 2) begin
      failures++; $display("FAIL cksum_bad got=%b/%0d exp=1/2", err, dm_cnt - base);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_imem();
    test_dmem_wrap();
    test_back_to_back_ib();
    test_cnt_zero();
    test_bad_header();
    test_reset_midframe();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    checks++;
    if (multi_we !== 0) begin
      failures++; $display("FAIL one_hot_we got=%0d exp=0", multi_we);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
